// File: rtl/axil_cmd_pkg.sv
// -----------------------------------------------------------------------------
// axil_cmd_pkg
// Shared types and constants for the AXI-Lite command master:
//   state_t     - command FSM state encoding
//   RESP_OKAY   - AXI OKAY response code
//   RESP_SLVERR - AXI SLVERR response code (also reported on timeout)
//   ctr_width() - bit width needed by the in-flight timeout counter
// -----------------------------------------------------------------------------
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // The counter only has to reach cyc-1, so clog2(cyc) bits suffice;
    // never return less than one bit.
    function automatic int ctr_width(input int cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/axil_cmd_if.sv
// -----------------------------------------------------------------------------
// axil_cmd_if
// Bundles the command channel, the response channel and the AXI-Lite master
// bus of axil_cmd_master.
//   modport master - view of axil_cmd_master (drives cmd_ready, rsp_*, m_* requests)
//   modport slave  - view of the command source / AXI-Lite slave side
// Parameter ADDR_W sets cmd_addr, m_awaddr and m_araddr width.
// -----------------------------------------------------------------------------
interface axil_cmd_if
    import axil_cmd_pkg::*;
#(
    parameter int ADDR_W = 32
);

    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;

    // AXI-Lite master bus
    logic              m_awvalid;
    logic              m_awready;
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_wvalid;
    logic              m_wready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_bvalid;
    logic              m_bready;
    logic [1:0]        m_bresp;
    logic              m_arvalid;
    logic              m_arready;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_rvalid;
    logic              m_rready;
    logic [31:0]       m_rdata;
    logic [1:0]        m_rresp;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        output m_arvalid, m_araddr, m_rready,
        input  m_awready, m_wready, m_bvalid, m_bresp,
        input  m_arready, m_rvalid, m_rdata, m_rresp
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
        input  m_arvalid, m_araddr, m_rready,
        output m_awready, m_wready, m_bvalid, m_bresp,
        output m_arready, m_rvalid, m_rdata, m_rresp
    );

endinterface

// File: rtl/axil_timeout_ctr.sv
// -----------------------------------------------------------------------------
// axil_timeout_ctr
// Counts cycles a transaction has been in flight.
//   clk_main_a0 - clock
//   rst_main_n  - asynchronous active-low reset
//   i_clear     - zero the count (has priority over i_enable)
//   i_enable    - count this cycle
//   o_expired   - count has reached LIMIT-1
// The count saturates at LIMIT-1, so once expired it stays expired until the
// next clear instead of wrapping and re-arming.
// -----------------------------------------------------------------------------
module axil_timeout_ctr
    import axil_cmd_pkg::*;
#(
    parameter int LIMIT = 256,
    parameter int WIDTH = ctr_width(LIMIT)
) (
    input  logic clk_main_a0,
    input  logic rst_main_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    assign o_expired = (r_count == LAST);

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/axil_cmd_master.sv
// -----------------------------------------------------------------------------
// axil_cmd_master
// Turns single commands (read or write) into AXI-Lite transactions and returns
// one response per command. A transaction that stays in flight for
// TIMEOUT_CYC cycles is abandoned and reported with rsp_timeout=1/SLVERR.
//   clk_main_a0 - clock
//   rst_main_n  - asynchronous active-low reset
//   bus         - axil_cmd_if.master: cmd_*, rsp_* and m_* AXI-Lite signals
// Parameters: TIMEOUT_CYC (in-flight cycle limit), ADDR_W (address width).
// Every output is a flop except cmd_ready, which decodes the state register.
// -----------------------------------------------------------------------------
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int ADDR_W      = 32
) (
    input  logic          clk_main_a0,
    input  logic          rst_main_n,
    axil_cmd_if.master    bus
);

    state_t            r_state, w_state_next;
    logic              r_rst_done;

    logic              r_awvalid, w_awvalid_next;
    logic              r_wvalid,  w_wvalid_next;
    logic              r_bready,  w_bready_next;
    logic              r_arvalid, w_arvalid_next;
    logic              r_rready,  w_rready_next;

    logic [ADDR_W-1:0] r_addr,    w_addr_next;
    logic [31:0]       r_wdata,   w_wdata_next;
    logic [3:0]        r_wstrb,   w_wstrb_next;

    logic              r_rsp_valid,   w_rsp_valid_next;
    logic              r_rsp_timeout, w_rsp_timeout_next;
    logic [1:0]        r_rsp_resp,    w_rsp_resp_next;
    logic [31:0]       r_rsp_rdata,   w_rsp_rdata_next;

    logic              w_cmd_ready;
    logic              w_accept;
    logic              w_ctr_clear;
    logic              w_ctr_enable;
    logic              w_expired;
    logic              w_abort;

    // r_rst_done keeps cmd_ready low while in reset and up to the first edge
    // after release, even though the state register already reads IDLE.
    assign w_cmd_ready  = (r_state == IDLE) && r_rst_done;
    assign w_accept     = bus.cmd_valid && w_cmd_ready;
    assign w_ctr_enable = (r_state == WR_REQ) || (r_state == WR_RESP) ||
                          (r_state == RD_REQ) || (r_state == RD_RESP);

    axil_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout_ctr (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .i_clear     (w_ctr_clear),
        .i_enable    (w_ctr_enable),
        .o_expired   (w_expired)
    );

    always_comb begin
        w_state_next       = r_state;
        w_awvalid_next     = r_awvalid;
        w_wvalid_next      = r_wvalid;
        w_bready_next      = r_bready;
        w_arvalid_next     = r_arvalid;
        w_rready_next      = r_rready;
        w_addr_next        = r_addr;
        w_wdata_next       = r_wdata;
        w_wstrb_next       = r_wstrb;
        w_rsp_valid_next   = r_rsp_valid;
        w_rsp_timeout_next = r_rsp_timeout;
        w_rsp_resp_next    = r_rsp_resp;
        w_rsp_rdata_next   = r_rsp_rdata;
        w_ctr_clear        = 1'b0;
        w_abort            = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ctr_clear  = 1'b1;
                    w_addr_next  = bus.cmd_addr;
                    w_wdata_next = bus.cmd_wdata;
                    w_wstrb_next = bus.cmd_wstrb;
                    if (bus.cmd_wr) begin
                        w_state_next   = WR_REQ;
                        w_awvalid_next = 1'b1;
                        w_wvalid_next  = 1'b1;
                    end else begin
                        w_state_next   = RD_REQ;
                        w_arvalid_next = 1'b1;
                    end
                end
            end

            WR_REQ: begin
                // AW and W retire independently; move on once neither is pending.
                w_awvalid_next = r_awvalid && !bus.m_awready;
                w_wvalid_next  = r_wvalid  && !bus.m_wready;
                if (!w_awvalid_next && !w_wvalid_next) begin
                    w_state_next  = WR_RESP;
                    w_bready_next = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end

            WR_RESP: begin
                if (bus.m_bvalid) begin
                    w_state_next       = RSP;
                    w_bready_next      = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_timeout_next = 1'b0;
                    w_rsp_resp_next    = bus.m_bresp;
                    w_rsp_rdata_next   = 32'h0;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end

            RD_REQ: begin
                if (bus.m_arready) begin
                    w_state_next   = RD_RESP;
                    w_arvalid_next = 1'b0;
                    w_rready_next  = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end

            RD_RESP: begin
                if (bus.m_rvalid) begin
                    w_state_next       = RSP;
                    w_rready_next      = 1'b0;
                    w_rsp_valid_next   = 1'b1;
                    w_rsp_timeout_next = 1'b0;
                    w_rsp_resp_next    = bus.m_rresp;
                    w_rsp_rdata_next   = bus.m_rdata;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end

            RSP: begin
                if (bus.rsp_ready) begin
                    w_state_next     = IDLE;
                    w_rsp_valid_next = 1'b0;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Expiry only aborts when no handshake finished the phase this cycle
        // (those branches are checked first above).
        if (w_abort) begin
            w_state_next       = RSP;
            w_awvalid_next     = 1'b0;
            w_wvalid_next      = 1'b0;
            w_bready_next      = 1'b0;
            w_arvalid_next     = 1'b0;
            w_rready_next      = 1'b0;
            w_rsp_valid_next   = 1'b1;
            w_rsp_timeout_next = 1'b1;
            w_rsp_resp_next    = RESP_SLVERR;
            w_rsp_rdata_next   = 32'h0;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state       <= IDLE;
            r_rst_done    <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 32'h0;
            r_wstrb       <= 4'h0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_rdata   <= 32'h0;
        end else begin
            r_state       <= w_state_next;
            r_rst_done    <= 1'b1;
            r_awvalid     <= w_awvalid_next;
            r_wvalid      <= w_wvalid_next;
            r_bready      <= w_bready_next;
            r_arvalid     <= w_arvalid_next;
            r_rready      <= w_rready_next;
            r_addr        <= w_addr_next;
            r_wdata       <= w_wdata_next;
            r_wstrb       <= w_wstrb_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_timeout <= w_rsp_timeout_next;
            r_rsp_resp    <= w_rsp_resp_next;
            r_rsp_rdata   <= w_rsp_rdata_next;
        end
    end

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.rsp_resp    = r_rsp_resp;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.m_awvalid   = r_awvalid;
    assign bus.m_awaddr    = r_addr;
    assign bus.m_wvalid    = r_wvalid;
    assign bus.m_wdata     = r_wdata;
    assign bus.m_wstrb     = r_wstrb;
    assign bus.m_bready    = r_bready;
    assign bus.m_arvalid   = r_arvalid;
    assign bus.m_araddr    = r_addr;
    assign bus.m_rready    = r_rready;

endmodule

// File: tb/tb_axil_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_axil_cmd_master
// Directed bench for axil_cmd_master with TIMEOUT_CYC=16. A small reactive
// AXI-Lite slave with per-channel wait knobs sits on the bus; commands are
// issued one at a time and responses compared with hand-computed values.
// Latency is counted in cycles from the accepting cycle (cycle 0).
// -----------------------------------------------------------------------------
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int ADDR_W = 32;
    localparam int TO_CYC = 16;
    localparam int NEVER  = 100000;

    logic clk_main_a0 = 1'b0;
    logic rst_main_n  = 1'b0;

    always #5 clk_main_a0 = ~clk_main_a0;

    axil_cmd_if #(.ADDR_W(ADDR_W)) bus ();

    axil_cmd_master #(
        .TIMEOUT_CYC (TO_CYC),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave knobs and monitor ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [31:0] sl_rdata = 32'h0;
    logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;

    int          aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0;
    logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
    logic [3:0]  cap_wstrb = 4'h0;

    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0, b_hs = 0, r_hs = 0;

    // Slave reacts on the falling edge; a ready/valid pair seen high here
    // completes at the following rising edge.
    initial begin : slave
        bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
        bus.m_bvalid  = 1'b0; bus.m_bresp  = 2'b00;
        bus.m_rvalid  = 1'b0; bus.m_rresp  = 2'b00; bus.m_rdata = 32'h0;
        forever begin
            @(negedge clk_main_a0);
            if (!rst_main_n) begin
                bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
                bus.m_bvalid  = 1'b0; bus.m_rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0;
            end else begin
                if (b_hs) begin
                    bus.m_bvalid = 1'b0; b_hs = 0;
                end else begin
                    if (b_pend && !bus.m_bvalid) begin
                        if (b_cnt >= b_delay) begin bus.m_bvalid = 1'b1; bus.m_bresp = sl_bresp; end
                        else b_cnt++;
                    end
                    if (bus.m_bvalid && bus.m_bready) begin b_hs = 1; b_pend = 0; b_cnt = 0; b_beats++; end
                end
                if (r_hs) begin
                    bus.m_rvalid = 1'b0; r_hs = 0;
                end else begin
                    if (r_pend && !bus.m_rvalid) begin
                        if (r_cnt >= r_delay) begin
                            bus.m_rvalid = 1'b1; bus.m_rdata = sl_rdata; bus.m_rresp = sl_rresp;
                        end else r_cnt++;
                    end
                    if (bus.m_rvalid && bus.m_rready) begin r_hs = 1; r_pend = 0; r_cnt = 0; r_beats++; end
                end
                if (bus.m_awready) bus.m_awready = 1'b0;
                else if (bus.m_awvalid) begin
                    if (aw_cnt >= aw_delay) begin
                        bus.m_awready = 1'b1; aw_cnt = 0; aw_beats++; cap_awaddr = bus.m_awaddr; aw_got = 1;
                    end else aw_cnt++;
                end else aw_cnt = 0;
                if (bus.m_wready) bus.m_wready = 1'b0;
                else if (bus.m_wvalid) begin
                    if (w_cnt >= w_delay) begin
                        bus.m_wready = 1'b1; w_cnt = 0; w_beats++;
                        cap_wdata = bus.m_wdata; cap_wstrb = bus.m_wstrb; w_got = 1;
                    end else w_cnt++;
                end else w_cnt = 0;
                if (bus.m_arready) bus.m_arready = 1'b0;
                else if (bus.m_arvalid) begin
                    if (ar_cnt >= ar_delay) begin
                        bus.m_arready = 1'b1; ar_cnt = 0; ar_beats++; cap_araddr = bus.m_araddr; r_pend = 1;
                    end else ar_cnt++;
                end else ar_cnt = 0;
                if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
            end
        end
    end

    int s_aw, s_w, s_ar, s_b, s_r;
    task automatic snap();
        s_aw = aw_beats; s_w = w_beats; s_ar = ar_beats; s_b = b_beats; s_r = r_beats;
    endtask

    // Issue one command, wait for its response, optionally keep rsp_ready low
    // for 'hold' cycles while poking cmd_valid, then complete the handshake.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                           input int exp_lat, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_resp, input logic exp_to);
        int guard;
        int lat;
        @(negedge clk_main_a0);
        bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wdata; bus.cmd_wstrb = wstrb;
        guard = 0;
        while (!bus.cmd_ready && guard < 50) begin @(negedge clk_main_a0); guard++; end
        if (!bus.cmd_ready) begin
            check_eq({name, "_accept"}, 64'(bus.cmd_ready), 64'(1));
            bus.cmd_valid = 1'b0;
            return;
        end
        lat = 0;
        do begin
            @(negedge clk_main_a0);
            lat++;
            if (lat == 1) bus.cmd_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 200);
        if (!bus.rsp_valid) begin
            check_eq({name, "_rsp_arrive"}, 64'(bus.rsp_valid), 64'(1));
            return;
        end
        check_eq({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({name, "_rsp"}, {27'h0, bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata},
                 {27'h0, exp_to, exp_resp, exp_rdata});
        check_eq({name, "_m_idle"}, 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid,
                                         bus.m_bready, bus.m_rready}), 64'(0));
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1;
            @(negedge clk_main_a0);
            check_eq({name, "_hold"},
                     {24'h0, bus.rsp_valid, bus.cmd_ready, bus.m_awvalid, bus.m_arvalid,
                      bus.rsp_timeout, bus.rsp_resp, bus.rsp_rdata},
                     {24'h0, 1'b1, 1'b0, 1'b0, 1'b0, exp_to, exp_resp, exp_rdata});
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk_main_a0);
        bus.rsp_ready = 1'b0;
        check_eq({name, "_back_idle"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'(2'b01));
        $display("txn %s wr=%0d addr=0x%08h lat=%0d resp=%0d timeout=%0d rdata=0x%08h",
                 name, wr, addr, lat, exp_resp, exp_to, exp_rdata);
    endtask

    initial begin : main
        int guard;
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk_main_a0);
        check_eq("rst_ctrl", 64'({bus.cmd_ready, bus.m_awvalid, bus.m_wvalid, bus.m_arvalid,
                                  bus.m_bready, bus.m_rready, bus.rsp_valid, bus.rsp_timeout}), 64'(0));
        check_eq("rst_rsp_fields", 64'({bus.rsp_resp, bus.rsp_rdata}), 64'(0));
        rst_main_n = 1'b1;
        #1;
        check_eq("rst_rel_before_edge", 64'(bus.cmd_ready), 64'(0));
        @(negedge clk_main_a0);
        check_eq("rst_rel_ready", 64'(bus.cmd_ready), 64'(1));
        $display("txn reset_release cmd_ready=%0d", bus.cmd_ready);

        // ---- zero-wait write ----
        snap();
        run_txn("wr_zero", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 3, 32'h0, RESP_OKAY, 1'b0);
        check_eq("wr_zero_beats", 64'({8'(aw_beats - s_aw), 8'(w_beats - s_w), 8'(b_beats - s_b)}),
                 64'(24'h010101));
        check_eq("wr_zero_awaddr", 64'(cap_awaddr), 64'(32'h10));
        check_eq("wr_zero_wdata", 64'({cap_wstrb, cap_wdata}), 64'({4'hF, 32'hDEADBEEF}));

        // ---- read with 5-cycle rvalid delay ----
        r_delay = 5; sl_rdata = 32'h12345678; sl_rresp = 2'b00;
        snap();
        run_txn("rd_slow", 1'b0, 32'h20, 32'h0, 4'h0, 0, 8, 32'h12345678, RESP_OKAY, 1'b0);
        check_eq("rd_slow_beats", 64'({8'(ar_beats - s_ar), 8'(r_beats - s_r)}), 64'(16'h0101));
        check_eq("rd_slow_araddr", 64'(cap_araddr), 64'(32'h20));

        // ---- zero-wait read returning SLVERR ----
        r_delay = 0; sl_rdata = 32'hA5A50F0F; sl_rresp = RESP_SLVERR;
        run_txn("rd_slverr", 1'b0, 32'h24, 32'h0, 4'h0, 0, 3, 32'hA5A50F0F, RESP_SLVERR, 1'b0);

        // ---- W ready four cycles after AW ----
        w_delay = 4; sl_bresp = RESP_SLVERR;
        snap();
        run_txn("wr_wlate", 1'b1, 32'h44, 32'hCAFEF00D, 4'h6, 0, 7, 32'h0, RESP_SLVERR, 1'b0);
        check_eq("wr_wlate_beats", 64'({8'(aw_beats - s_aw), 8'(w_beats - s_w), 8'(b_beats - s_b)}),
                 64'(24'h010101));
        check_eq("wr_wlate_wdata", 64'({cap_wstrb, cap_wdata}), 64'({4'h6, 32'hCAFEF00D}));

        // ---- AW ready three cycles after W ----
        w_delay = 0; aw_delay = 3; sl_bresp = RESP_OKAY;
        snap();
        run_txn("wr_awlate", 1'b1, 32'h48, 32'h0BADF00D, 4'h1, 0, 6, 32'h0, RESP_OKAY, 1'b0);
        check_eq("wr_awlate_beats", 64'({8'(aw_beats - s_aw), 8'(w_beats - s_w)}), 64'(16'h0101));
        check_eq("wr_awlate_awaddr", 64'(cap_awaddr), 64'(32'h48));
        aw_delay = 0;

        // ---- read timeout: arready never comes ----
        ar_delay = NEVER;
        snap();
        run_txn("rd_timeout", 1'b0, 32'h30, 32'h0, 4'h0, 0, TO_CYC + 1, 32'h0, RESP_SLVERR, 1'b1);
        check_eq("rd_timeout_no_ar", 64'(ar_beats - s_ar), 64'(0));

        // ---- arready on the expiry cycle: handshake wins ----
        ar_delay = TO_CYC - 1; sl_rdata = 32'h600DCAFE; sl_rresp = RESP_OKAY;
        run_txn("rd_edge", 1'b0, 32'h34, 32'h0, 4'h0, 0, TO_CYC + 2, 32'h600DCAFE, RESP_OKAY, 1'b0);
        ar_delay = 0;

        // ---- response back-pressure for 10 cycles, then a new command ----
        run_txn("wr_hold", 1'b1, 32'h50, 32'h11223344, 4'hF, 10, 3, 32'h0, RESP_OKAY, 1'b0);
        sl_rdata = 32'h55667788;
        run_txn("rd_after_hold", 1'b0, 32'h54, 32'h0, 4'h0, 0, 3, 32'h55667788, RESP_OKAY, 1'b0);

        // ---- reset pulse while waiting in WR_RESP ----
        b_delay = NEVER;
        @(negedge clk_main_a0);
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h60;
        bus.cmd_wdata = 32'h77777777; bus.cmd_wstrb = 4'hF;
        guard = 0;
        do begin
            @(negedge clk_main_a0);
            bus.cmd_valid = 1'b0;
            guard++;
        end while (!bus.m_bready && guard < 20);
        check_eq("rstmid_in_wr_resp", 64'(bus.m_bready), 64'(1));
        #2 rst_main_n = 1'b0;
        #1;
        check_eq("rstmid_async_drop", 64'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready,
                                           bus.m_rready, bus.rsp_valid, bus.cmd_ready}), 64'(0));
        repeat (2) @(negedge clk_main_a0);
        check_eq("rstmid_no_rsp", 64'({bus.rsp_valid, bus.cmd_ready}), 64'(0));
        b_delay = 0;
        rst_main_n = 1'b1;
        #1;
        check_eq("rstmid_rel_before_edge", 64'(bus.cmd_ready), 64'(0));
        @(negedge clk_main_a0);
        check_eq("rstmid_rel_ready", 64'({bus.cmd_ready, bus.rsp_valid, bus.m_bready}), 64'(3'b100));
        $display("txn reset_mid_wr_resp cmd_ready=%0d rsp_valid=%0d", bus.cmd_ready, bus.rsp_valid);

        // ---- normal write after the aborted one ----
        snap();
        run_txn("wr_post_rst", 1'b1, 32'h70, 32'h89ABCDEF, 4'hC, 0, 3, 32'h0, RESP_OKAY, 1'b0);
        check_eq("wr_post_rst_data", 64'({cap_awaddr, cap_wdata}), {32'h70, 32'h89ABCDEF});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, max cycles a transaction may stay in flight before abort.
REQ-002 SHALL have parameter ADDR_W, default 32, AXI-Lite address width.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk_main_a0  in  1  clock
- rst_main_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  AXI resp code
- rsp_timeout  out  1  transaction aborted by timeout
- m_awvalid, m_awaddr[ADDR_W], m_wvalid, m_wdata[32], m_wstrb[4], m_bready, m_arvalid, m_araddr[ADDR_W], m_rready  out  AXI-Lite master outputs
- m_awready, m_wready, m_bvalid, m_bresp[2], m_arready, m_rvalid, m_rdata[32], m_rresp[2]  in  AXI-Lite master inputs
REQ-004 SHALL use reset rst_main_n (asynchronous, active-low) and clock clk_main_a0.

Function
REQ-005 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-006 Command handshake and requests:
- cmd_ready SHALL be 1 only in IDLE.
- cmd_valid&cmd_ready SHALL latch addr/data/strb and go to WR_REQ (cmd_wr=1) or RD_REQ (cmd_wr=0).
REQ-007 Write request:
- In WR_REQ, m_awvalid and m_wvalid SHALL assert together on the cycle after command acceptance.
- Each SHALL drop independently the cycle after its own handshake.
- When both are done, go to WR_RESP; AW and W may complete in either order or the same cycle.
REQ-008 m_bready SHALL be 1 only in WR_RESP; on m_bvalid&m_bready, capture m_bresp, rsp_rdata=0, go to RSP.
REQ-009 Read request: in RD_REQ, m_arvalid SHALL be 1 until m_arready, then go to RD_RESP.
REQ-010 m_rready SHALL be 1 only in RD_RESP; on m_rvalid&m_rready, capture m_rdata and m_rresp, go to RSP.
REQ-011 Response:
- In RSP, rsp_valid=1 with fields stable until rsp_ready, then return to IDLE.
- Minimum latency, command accept to rsp_valid: 3 cycles with zero-wait slave.
REQ-012 Timeout:
- Counter SHALL clear on command acceptance and increment each cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
- On reaching TIMEOUT_CYC-1: deassert all m_* valids/readies next cycle, go to RSP with rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-013 A handshake completing in the same cycle as timeout expiry SHALL win; the response is normal and rsp_timeout=0.
REQ-014 All outputs SHALL be registered. The one exception is cmd_ready, which is a decode of the state register.
REQ-015 m_awaddr/m_araddr/m_wdata/m_wstrb SHALL hold the latched command values while the corresponding valid is 1.

Reset
REQ-016 Reset SHALL force state IDLE and the following outputs to 0: m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, and the counter.
REQ-017 While rst_main_n=0, cmd_ready SHALL be 0; it SHALL be 1 from the first clock edge after deassertion.
REQ-018 Reset asserted mid-transaction SHALL drop all m_* valids/readies asynchronously and discard the transaction (no response).

Structure
REQ-019 Package axil_cmd_pkg SHALL hold the state enum, resp codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, and the timeout counter width function.
REQ-020 The timeout counter SHALL be sub-module axil_timeout_ctr (clear, enable, expired).

Verification
REQ-021 Write 0x10 <- 0xDEADBEEF, strb 0xF, zero-wait slave -> AW/W beats carry those values; rsp_valid at cycle 3, rsp_resp=0, rsp_rdata=0.
REQ-022 Read 0x20, slave returns 0x12345678 after 5-cycle rvalid delay -> rsp_rdata=0x12345678, rsp_resp=0, rsp_timeout=0.
REQ-023 Write with m_wready 4 cycles later than m_awready -> single AW, single W, one response, FSM back to IDLE.
REQ-024 Read with m_arready never asserted, TIMEOUT_CYC=16 -> m_arvalid drops; rsp_timeout=1, rsp_resp=2'b10, rsp_rdata=0.
REQ-025 rsp_ready held 0 for 10 cycles -> rsp fields stable and cmd_ready=0 throughout; new command accepted only after the handshake.
REQ-026 rst_main_n pulsed low during WR_RESP -> all m_* outputs 0 immediately, no rsp_valid, cmd_ready=1 the first edge after release.
